fetch_queue: RTL and testbench

Instruction prefetch queue between instruction memory and the `if_id` pipeline register. Issues sequential fetch requests from a running PC, buffers returned words with their PCs in order, and presents one instruction per cycle to decode. Honours `stallF` and discards all queued and in-flight fetches on a branch or jump redirect.

---
 rtl/fetch_queue_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 132 +++++++++++++
 tb/tb_fetch_queue.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the instruction prefetch queue.
package fetch_queue_pkg;

    localparam int                     WORD_WIDTH       = 32;
    localparam logic [WORD_WIDTH-1:0]  ZERO_WORD        = '0;
    localparam logic [WORD_WIDTH-1:0]  RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [WORD_WIDTH-1:0]  PC_STEP          = 32'd4;

    // One queue slot: fetch address and the word returned for it.
    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] data;
    } fq_entry_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [WORD_WIDTH-1:0] next_pc(input logic [WORD_WIDTH-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential imem requests from a running
// PC, buffers returned words in order with their PCs, presents the head entry
// to decode, and discards everything queued or in flight on a redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                    DEPTH        = 4,
    parameter int                    MAX_INFLIGHT = 2*DEPTH,
    parameter logic [WORD_WIDTH-1:0] RESET_PC     = RESET_PC_DEFAULT
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect,
    input  logic [WORD_WIDTH-1:0] redirect_pc,
    input  logic                  stallF,
    output logic                  imem_req_valid,
    output logic [WORD_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [WORD_WIDTH-1:0] imem_resp_data,
    output logic                  instr_valid,
    output logic [WORD_WIDTH-1:0] instrF,
    output logic [WORD_WIDTH-1:0] pcF
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [IW-1:0] MAX_C   = IW'(MAX_INFLIGHT);

    fq_entry_t             r_entry [DEPTH];
    logic [DEPTH-1:0]      r_filled;
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_fill;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_alloc_cnt;
    logic [IW-1:0]         r_inflight;
    logic [IW-1:0]         r_drop_cnt;
    logic [WORD_WIDTH-1:0] r_fetch_pc;

    logic                  w_req_valid;
    logic                  w_fire;
    logic                  w_head_valid;
    logic                  w_pop;
    logic                  w_resp_live;
    logic                  w_resp_write;
    logic                  w_resp_drop;
    logic [IW-1:0]         w_resp_dec;

    // Request, pop and response qualification; redirect and reset block all of it.
    always_comb begin
        w_req_valid  = !rst && !redirect && (r_alloc_cnt < DEPTH_C) && (r_inflight < MAX_C);
        w_fire       = w_req_valid && imem_req_ready;
        w_head_valid = (r_alloc_cnt != '0) && r_filled[r_head];
        w_pop        = w_head_valid && !stallF && !redirect;
        w_resp_live  = imem_resp_valid && !rst && !redirect;
        w_resp_drop  = w_resp_live && (r_drop_cnt != '0);
        w_resp_write = w_resp_live && (r_drop_cnt == '0);
        w_resp_dec   = IW'(imem_resp_valid);
    end

    // Entry payload; only read behind the filled/alloc qualification, so no reset.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_entry[r_tail].pc <= r_fetch_pc;
        end
        if (w_resp_write) begin
            r_entry[r_fill].data <= imem_resp_data;
        end
    end

    // Pointers, counters, filled bits and the running fetch PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc  <= RESET_PC;
            r_filled    <= '0;
            r_head      <= '0;
            r_fill      <= '0;
            r_tail      <= '0;
            r_alloc_cnt <= '0;
            r_inflight  <= '0;
            r_drop_cnt  <= '0;
        end else if (redirect) begin
            r_fetch_pc  <= redirect_pc;
            r_filled    <= '0;
            r_head      <= '0;
            r_fill      <= '0;
            r_tail      <= '0;
            r_alloc_cnt <= '0;
            r_inflight  <= r_inflight - w_resp_dec;
            // inflight already counts words still owed to an earlier redirect,
            // so every outstanding word except the one landing now is stale.
            r_drop_cnt  <= (r_inflight > w_resp_dec) ? (r_inflight - w_resp_dec) : '0;
        end else begin
            if (w_fire) begin
                r_filled[r_tail] <= 1'b0;
                r_tail           <= r_tail + PW'(1);
                r_fetch_pc       <= next_pc(r_fetch_pc);
            end
            if (w_resp_drop) begin
                r_drop_cnt <= r_drop_cnt - IW'(1);
            end
            if (w_resp_write) begin
                r_filled[r_fill] <= 1'b1;
                r_fill           <= r_fill + PW'(1);
            end
            if (w_pop) begin
                r_filled[r_head] <= 1'b0;
                r_head           <= r_head + PW'(1);
            end
            case ({w_fire, w_pop})
                2'b10:   r_alloc_cnt <= r_alloc_cnt + CW'(1);
                2'b01:   r_alloc_cnt <= r_alloc_cnt - CW'(1);
                default: r_alloc_cnt <= r_alloc_cnt;
            endcase
            case ({w_fire, imem_resp_valid})
                2'b10:   r_inflight <= r_inflight + IW'(1);
                2'b01:   r_inflight <= r_inflight - IW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign instr_valid    = w_head_valid;
    assign instrF         = w_head_valid ? r_entry[r_head].data : ZERO_WORD;
    assign pcF            = w_head_valid ? r_entry[r_head].pc   : ZERO_WORD;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: an in-order memory model with selectable
// latency, an expected-instruction queue filled as requests fire, and a
// monitor that pops and compares every instruction decode accepts.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stallF;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic [31:0] instrF;
    logic [31:0] pcF;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .stallF          (stallF),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instrF          (instrF),
        .pcF             (pcF)
    );

    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] data; int due; } mem_t;

    exp_t        exp_q[$];
    mem_t        mem_q[$];
    exp_t        e_s;
    mem_t        m_s;
    logic [31:0] model_pc = 32'h0000_3000;
    int          last_due = 0;
    int          cyc      = 0;
    int          lat_fixed = 1;   // 0 selects random latency 1..4
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fire   = 0;
    int          n_pop    = 0;
    logic        fire_s;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory response driver: in order, one word per cycle at its due cycle.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_q[0].data;
            void'(mem_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
    end

    // Monitor / scoreboard: reference fetch stream, memory request capture, pop compare.
    always @(negedge clk) begin
        fire_s = imem_req_valid && imem_req_ready;
        if (rst) begin
            mem_q.delete();
            exp_q.delete();
            last_due = 0;
            model_pc = 32'h0000_3000;
        end else begin
            if (redirect) begin
                exp_q.delete();
                model_pc = redirect_pc;
            end else if (instr_valid && !stallF) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pop_unexpected: got pc %h, expected no instruction (cycle %0d)", pcF, cyc);
                end else begin
                    e_s = exp_q.pop_front();
                    chk("pop_pc", pcF, e_s.pc);
                    chk("pop_instr", instrF, e_s.data);
                end
            end
            if (fire_s) begin
                n_fire++;
                chk("req_addr", imem_req_addr, model_pc);
                e_s.pc   = model_pc;
                e_s.data = word_of(model_pc);
                exp_q.push_back(e_s);
                m_s.data = word_of(imem_req_addr);
                m_s.due  = cyc + ((lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4)));
                if (m_s.due <= last_due) m_s.due = last_due + 1;
                last_due = m_s.due;
                mem_q.push_back(m_s);
                model_pc = model_pc + 32'd4;
            end
        end
    end

    initial begin
        int pops_before;
        logic [31:0] r;
        rst             = 1'b1;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        stallF          = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;

        // Reset state
        tick();
        @(negedge clk);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instrF", instrF, 32'h0);
        chk("rst_pcF", pcF, 32'h0);
        chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        tick();

        // L=1, ready high: streaming from RESET_PC
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
                chk("first_req_addr", imem_req_addr, 32'h0000_3000);
            end
            if (k < 2) chk("stream_valid_early", {31'h0, instr_valid}, 32'h0);
            else begin
                chk("stream_valid", {31'h0, instr_valid}, 32'h1);
                chk("stream_pcF", pcF, 32'h3000 + 32'(4*(k-2)));
            end
            tick();
        end

        // Stall for 10 cycles: queue fills with exactly 4 requests
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        stallF = 1'b1;
        n_fire = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 9) begin
                @(negedge clk);
                chk("full_req_valid", {31'h0, imem_req_valid}, 32'h0);
                chk("full_pcF_held", pcF, 32'h0000_3000);
                chk("full_instr_valid", {31'h0, instr_valid}, 32'h1);
            end
            tick();
        end
        chk("stall_fire_count", 32'(n_fire), 32'd4);
        stallF = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("release_valid", {31'h0, instr_valid}, 32'h1);
            chk("release_pcF", pcF, 32'h3000 + 32'(4*k));
            tick();
        end

        // L=4, redirect with 4 in flight, same cycle as a response and stallF
        rst       = 1'b1;
        lat_fixed = 4;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_4000;
        stallF      = 1'b1;
        @(negedge clk);
        chk("redir_no_req", {31'h0, imem_req_valid}, 32'h0);
        tick();
        redirect = 1'b0;
        stallF   = 1'b0;
        for (int k = 5; k <= 10; k++) begin
            @(negedge clk);
            if (k == 5) begin
                chk("redir_req_valid", {31'h0, imem_req_valid}, 32'h1);
                chk("redir_req_addr", imem_req_addr, 32'h0000_4000);
            end
            if (k < 10) chk("redir_bubble", {31'h0, instr_valid}, 32'h0);
            else begin
                chk("redir_first_valid", {31'h0, instr_valid}, 32'h1);
                chk("redir_first_pcF", pcF, 32'h0000_4000);
                chk("redir_first_instr", instrF, word_of(32'h0000_4000));
            end
            tick();
        end

        // Reset with 3 requests outstanding
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        tick();
        rst = 1'b0;
        for (int k = 4; k <= 9; k++) begin
            @(negedge clk);
            if (k == 4) begin
                chk("postrst_instr_valid", {31'h0, instr_valid}, 32'h0);
                chk("postrst_instrF", instrF, 32'h0);
                chk("postrst_pcF", pcF, 32'h0);
                chk("postrst_req_valid", {31'h0, imem_req_valid}, 32'h1);
                chk("postrst_req_addr", imem_req_addr, 32'h0000_3000);
            end
            if (k == 9) begin
                chk("postrst_first_valid", {31'h0, instr_valid}, 32'h1);
                chk("postrst_first_pcF", pcF, 32'h0000_3000);
            end
            tick();
        end

        // Random backpressure, latency, stalls and redirects
        lat_fixed   = 0;
        pops_before = n_pop;
        for (int k = 0; k < 3000; k++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            stallF         = ($urandom_range(0, 9) < 3);
            rst            = ($urandom_range(0, 599) == 0);
            redirect       = !rst && ($urandom_range(0, 39) == 0);
            r              = $urandom;
            if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 + {28'h0, r[1:0], 2'b00};
            else                           redirect_pc = {r[31:2], 2'b00};
            tick();
        end
        rst            = 1'b0;
        redirect       = 1'b0;
        stallF         = 1'b0;
        imem_req_ready = 1'b1;
        for (int k = 0; k < 20; k++) tick();

        n_checks++;
        if (n_pop - pops_before >= 300) n_pass++;
        else $display("FAIL random_pop_count: got %0d, expected at least 300", n_pop - pops_before);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
